// File: rtl/pmcc_instr_encoder.sv
// pmcc_instr_encoder: packs symbolic PMC coprocessor commands into
// variable-length instruction sequences and writes them word by word
// into PMC code memory.
module pmcc_instr_encoder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [23:0]       cmd_arg,
    input  logic [31:0]       cmd_word0,
    input  logic [31:0]       cmd_word1,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              busy,
    output logic              err_ovf,
    output logic              err_illegal,
    input  logic              err_clr
);

    // One extra bit so the pointer can sit at MEM_DEPTH without wrapping.
    localparam int unsigned PTR_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_W0,
        S_W1
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [1:0]          extra_q, extra_d;
    logic [31:0]         w0_q, w0_d;
    logic [31:0]         w1_q, w1_d;
    logic                err_ovf_q, err_ovf_d;
    logic                err_ill_q, err_ill_d;

    logic [2:0]          opc_c;
    logic [1:0]          extra_c;
    logic                legal_c;
    logic                fits_c;
    logic                set_ovf_c;
    logic                set_ill_c;

    // Header opcode and extra-word count for the presented command.
    always_comb begin
        opc_c   = 3'b000;
        extra_c = 2'd0;
        legal_c = 1'b1;
        case (cmd_op)
            3'd0:    begin opc_c = 3'b000; extra_c = 2'd0; end
            3'd1:    begin opc_c = 3'b001; extra_c = 2'd1; end
            3'd2:    begin opc_c = 3'b010; extra_c = 2'd1; end
            3'd3:    begin opc_c = 3'b110; extra_c = 2'd2; end
            3'd4:    begin opc_c = 3'b100; extra_c = 2'd2; end
            default: legal_c = 1'b0;
        endcase
        fits_c = (ptr_q + PTR_W'(extra_c) + PTR_W'(1)) <= PTR_W'(MEM_DEPTH);
    end

    // Ready only when idle, out of reset, and no pointer load competing.
    assign cmd_ready = (state_q == S_IDLE) && !rst && !base_load;

    // Next-state, write sequencing and sticky error logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        extra_d     = extra_q;
        w0_d        = w0_q;
        w1_d        = w1_q;
        set_ovf_c   = 1'b0;
        set_ill_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (base_load) begin
                    ptr_d = PTR_W'(base_addr);
                end else if (cmd_valid) begin
                    if (!legal_c) begin
                        set_ill_c = 1'b1;
                    end else if (!fits_c) begin
                        set_ovf_c = 1'b1;
                    end else begin
                        state_d     = S_HDR;
                        extra_d     = extra_c;
                        w0_d        = cmd_word0;
                        w1_d        = cmd_word1;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = ptr_q[ADDR_W-1:0];
                        mem_wdata_d = {cmd_arg, opc_c, 5'b00000};
                    end
                end
            end
            S_HDR: begin
                if (mem_gnt) begin
                    ptr_d = ptr_q + PTR_W'(1);
                    if (extra_q == 2'd0) begin
                        state_d   = S_IDLE;
                        mem_req_d = 1'b0;
                    end else begin
                        state_d     = S_W0;
                        mem_addr_d  = mem_addr_q + ADDR_W'(1);
                        mem_wdata_d = w0_q;
                    end
                end
            end
            S_W0: begin
                if (mem_gnt) begin
                    ptr_d = ptr_q + PTR_W'(1);
                    if (extra_q == 2'd2) begin
                        state_d     = S_W1;
                        mem_addr_d  = mem_addr_q + ADDR_W'(1);
                        mem_wdata_d = w1_q;
                    end else begin
                        state_d   = S_IDLE;
                        mem_req_d = 1'b0;
                    end
                end
            end
            S_W1: begin
                if (mem_gnt) begin
                    ptr_d     = ptr_q + PTR_W'(1);
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        // A new error wins over a clear in the same cycle.
        err_ovf_d = set_ovf_c | (err_ovf_q & ~err_clr);
        err_ill_d = set_ill_c | (err_ill_q & ~err_clr);
    end

    // State and output registers; reset discards any in-flight command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            extra_q     <= '0;
            w0_q        <= '0;
            w1_q        <= '0;
            err_ovf_q   <= 1'b0;
            err_ill_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            extra_q     <= extra_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
            err_ovf_q   <= err_ovf_d;
            err_ill_q   <= err_ill_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign wr_ptr      = ptr_q[ADDR_W-1:0];
    assign busy        = (state_q != S_IDLE);
    assign err_ovf     = err_ovf_q;
    assign err_illegal = err_ill_q;

endmodule
